snes_pad_responder: RTL and testbench

SNES_PAD_RESPONDER -- requirements
Module: snes_pad_responder

---
 rtl/snes_pad_responder.sv | 164 ++++++++++++++++
 tb/tb_snes_pad_responder.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/snes_pad_responder.sv
// SNES controller responder: answers the console's latch/clock protocol with the
// 12 button states serialised LSB first, active-low, followed by four released bits.
module snes_pad_responder #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 2048
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [11:0] buttons,
    input  logic        joy_strb,
    input  logic        joy_clk,
    output logic        joy_data,
    output logic        poll,
    output logic [4:0]  bit_idx,
    output logic        active
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LATCH, SHIFT, DONE} state_t;

    logic [SYNC_STAGES-1:0] r_strbSync;
    logic [SYNC_STAGES-1:0] r_clkSync;
    logic                   r_strbHist;
    logic                   r_clkHist;
    state_t                 r_state;
    logic [15:0]            r_shift;
    logic [TW-1:0]          r_timeout;
    logic                   r_joyData;
    logic                   r_poll;
    logic [4:0]             r_bitIdx;
    logic                   r_active;

    logic          w_strb;
    logic          w_strbFall;
    logic          w_clkRise;
    state_t        w_stateNext;
    logic          w_dataNext;
    logic          w_pollNext;
    logic [4:0]    w_idxNext;
    logic [4:0]    w_idxPlus;
    logic          w_loadShift;
    logic [TW-1:0] w_toNext;

    assign w_strb     = r_strbSync[SYNC_STAGES-1];
    assign w_strbFall = r_strbHist & ~w_strb;
    assign w_clkRise  = r_clkSync[SYNC_STAGES-1] & ~r_clkHist;
    assign w_idxPlus  = r_bitIdx + 5'd1;

    always_comb begin
        w_stateNext = r_state;
        w_dataNext  = r_joyData;
        w_pollNext  = 1'b0;
        w_idxNext   = r_bitIdx;
        w_loadShift = 1'b0;
        w_toNext    = r_timeout;
        // A high strobe overrides everything, including a coincident clock edge
        if (w_strb) begin
            w_stateNext = LATCH;
            w_loadShift = 1'b1;
            w_dataNext  = ~buttons[0];
            w_idxNext   = 5'd0;
            w_toNext    = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_dataNext = 1'b1;
                    w_idxNext  = 5'd0;
                    w_toNext   = '0;
                end
                LATCH: begin
                    w_toNext = '0;
                    if (w_strbFall) begin
                        w_stateNext = SHIFT;
                        w_pollNext  = 1'b1;
                        w_dataNext  = ~r_shift[0];
                        w_idxNext   = 5'd0;
                    end else begin
                        w_loadShift = 1'b1;
                        w_dataNext  = ~buttons[0];
                    end
                end
                SHIFT: begin
                    if (w_clkRise) begin
                        w_toNext = '0;
                        if (r_bitIdx == 5'd15) begin
                            w_stateNext = DONE;
                            w_idxNext   = 5'd16;
                            w_dataNext  = 1'b0;
                        end else begin
                            w_idxNext  = w_idxPlus;
                            w_dataNext = ~r_shift[w_idxPlus[3:0]];
                        end
                    end else if (r_timeout == TIMEOUT_LAST) begin
                        w_stateNext = IDLE;
                        w_dataNext  = 1'b1;
                        w_idxNext   = 5'd0;
                        w_toNext    = '0;
                    end else if (r_timeout != '1) begin
                        w_toNext = r_timeout + 1'b1;
                    end
                end
                DONE: begin
                    w_dataNext = 1'b0;
                    w_idxNext  = 5'd16;
                    if (w_clkRise) begin
                        w_toNext = '0;
                    end else if (r_timeout == TIMEOUT_LAST) begin
                        w_stateNext = IDLE;
                        w_dataNext  = 1'b1;
                        w_idxNext   = 5'd0;
                        w_toNext    = '0;
                    end else if (r_timeout != '1) begin
                        w_toNext = r_timeout + 1'b1;
                    end
                end
                default: begin
                    w_stateNext = IDLE;
                    w_dataNext  = 1'b1;
                    w_idxNext   = 5'd0;
                    w_toNext    = '0;
                end
            endcase
        end
    end

    // Outputs are registered from their next-state values so no input reaches a pin combinationally
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_strbSync <= '0;
            r_clkSync  <= '0;
            r_strbHist <= 1'b0;
            r_clkHist  <= 1'b0;
            r_state    <= IDLE;
            r_shift    <= '0;
            r_timeout  <= '0;
            r_joyData  <= 1'b1;
            r_poll     <= 1'b0;
            r_bitIdx   <= 5'd0;
            r_active   <= 1'b0;
        end else begin
            r_strbSync <= {r_strbSync[SYNC_STAGES-2:0], joy_strb};
            r_clkSync  <= {r_clkSync[SYNC_STAGES-2:0], joy_clk};
            r_strbHist <= w_strb;
            r_clkHist  <= r_clkSync[SYNC_STAGES-1];
            r_state    <= w_stateNext;
            if (w_loadShift) begin
                r_shift <= {4'b0000, buttons};
            end
            r_timeout  <= w_toNext;
            r_joyData  <= w_dataNext;
            r_poll     <= w_pollNext;
            r_bitIdx   <= w_idxNext;
            r_active   <= (w_stateNext != IDLE);
        end
    end

    assign joy_data = r_joyData;
    assign poll     = r_poll;
    assign bit_idx  = r_bitIdx;
    assign active   = r_active;

endmodule

// File: tb/tb_snes_pad_responder.sv
// Scoreboard bench for snes_pad_responder: expected pad outputs are queued as the
// console pins are driven and compared once the synchronised response has settled.
module tb_snes_pad_responder;

    localparam int TO = 2048;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [11:0] buttons = '0;
    logic        joy_strb = 1'b0;
    logic        joy_clk = 1'b0;
    logic        joy_data;
    logic        poll;
    logic [4:0]  bit_idx;
    logic        active;

    typedef struct {
        string      tag;
        logic       data;
        logic [4:0] idx;
        logic       act;
    } exp_t;

    exp_t sbQ[$];
    int   testCount = 0;
    int   failCount = 0;
    int   pollCount = 0;
    int   pollBase;

    always #5 clk = ~clk;

    snes_pad_responder #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TO)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .buttons  (buttons),
        .joy_strb (joy_strb),
        .joy_clk  (joy_clk),
        .joy_data (joy_data),
        .poll     (poll),
        .bit_idx  (bit_idx),
        .active   (active)
    );

    // Poll pulses are counted continuously; tests compare against a snapshot
    always @(negedge clk) begin
        if (poll === 1'b1) pollCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic strb, input logic sclk, input int n);
        joy_strb = strb;
        joy_clk  = sclk;
        repeat (n) @(negedge clk);
    endtask

    task automatic pushExp(input string tag, input logic d, input logic [4:0] i, input logic a);
        exp_t e;
        e.tag  = tag;
        e.data = d;
        e.idx  = i;
        e.act  = a;
        sbQ.push_back(e);
    endtask

    task automatic drainCheck();
        exp_t e;
        while (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            checkOutput({e.tag, ".data"}, {31'd0, joy_data}, {31'd0, e.data});
            checkOutput({e.tag, ".idx"}, {27'd0, bit_idx}, {27'd0, e.idx});
            checkOutput({e.tag, ".active"}, {31'd0, active}, {31'd0, e.act});
        end
    endtask

    function automatic logic expBit(input logic [11:0] b, input int k);
        return (k < 12) ? ~b[k] : 1'b1;
    endfunction

    task automatic fullPoll(input string tag, input logic [11:0] latchBtn, input logic [11:0] shiftBtn, input int pulses);
        buttons = latchBtn;
        applyStimulus(1'b1, 1'b0, 6);
        pushExp({tag, ".latch"}, ~latchBtn[0], 5'd0, 1'b1);
        drainCheck();
        applyStimulus(1'b0, 1'b0, 6);
        buttons = shiftBtn;
        pushExp({tag, ".bit0"}, expBit(latchBtn, 0), 5'd0, 1'b1);
        drainCheck();
        for (int k = 1; k <= pulses; k++) begin
            applyStimulus(1'b0, 1'b1, 4);
            applyStimulus(1'b0, 1'b0, 4);
            if (k < 16)
                pushExp($sformatf("%s.p%0d", tag, k), expBit(latchBtn, k), 5'(k), 1'b1);
            else
                pushExp($sformatf("%s.p%0d", tag, k), 1'b0, 5'd16, 1'b1);
            drainCheck();
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        pushExp("reset", 1'b1, 5'd0, 1'b0);
        drainCheck();
        checkOutput("reset.poll", {31'd0, poll}, 32'd0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        pollBase = pollCount;
        fullPoll("btnB", 12'h001, 12'h001, 18);
        checkOutput("btnB.polls", pollCount - pollBase, 32'd1);

        pollBase = pollCount;
        fullPoll("btnA50", 12'hA50, 12'hA50, 18);
        checkOutput("btnA50.polls", pollCount - pollBase, 32'd1);

        fullPoll("frozen", 12'hFFF, 12'h000, 12);

        fullPoll("timeout", 12'h3C5, 12'h3C5, 5);
        applyStimulus(1'b0, 1'b0, TO - 50);
        pushExp("timeout.before", expBit(12'h3C5, 5), 5'd5, 1'b1);
        drainCheck();
        applyStimulus(1'b0, 1'b0, 100);
        pushExp("timeout.idle", 1'b1, 5'd0, 1'b0);
        drainCheck();
        fullPoll("restart", 12'h0F0, 12'h0F0, 0);

        fullPoll("collide", 12'h0F3, 12'h0F3, 7);
        applyStimulus(1'b1, 1'b1, 6);
        pushExp("collide.latch", ~buttons[0], 5'd0, 1'b1);
        drainCheck();
        applyStimulus(1'b0, 1'b0, 6);
        pushExp("collide.bit0", expBit(12'h0F3, 0), 5'd0, 1'b1);
        drainCheck();

        fullPoll("midreset", 12'h555, 12'h555, 9);
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        pushExp("midreset.async", 1'b1, 5'd0, 1'b0);
        drainCheck();
        checkOutput("midreset.poll", {31'd0, poll}, 32'd0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b1, 4);
            applyStimulus(1'b0, 1'b0, 4);
            pushExp($sformatf("afterreset.p%0d", k), 1'b1, 5'd0, 1'b0);
            drainCheck();
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
